// File: rtl/fir_pkg.sv
// Shared state encodings and width helpers for the time-multiplexed FIR filter.
package fir_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MAC  = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    function automatic int fir_clog2(input int value);
        int result;
        int span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span * 2;
            result = result + 1;
        end
        return result;
    endfunction

    // Full-precision accumulator width: NTAPS products never overflow it.
    function automatic int acc_width(input int dw, input int cw, input int ntaps);
        return dw + cw + fir_clog2(ntaps);
    endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational round-half-up by SHIFT followed by saturation to DW signed bits.
module fir_round_sat #(
    parameter int AW    = 35,
    parameter int DW    = 16,
    parameter int SHIFT = 15
) (
    input  logic signed [AW-1:0] acc_in,
    output logic signed [DW-1:0] y_sat
);

    // One guard bit so the rounding bias cannot wrap the accumulator.
    localparam int EW = AW + 1;
    localparam logic signed [EW-1:0] MAX_V = {{(EW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [EW-1:0] MIN_V = {{(EW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    logic signed [EW-1:0] ext_w;
    logic signed [EW-1:0] rounded_w;
    logic signed [EW-1:0] shifted_w;

    assign ext_w = {acc_in[AW-1], acc_in};

    generate
        if (SHIFT > 0) begin : g_round
            localparam logic [EW-1:0] BIAS = EW'(1) << (SHIFT - 1);
            assign rounded_w = ext_w + $signed(BIAS);
        end else begin : g_no_round
            assign rounded_w = ext_w;
        end
    endgenerate

    assign shifted_w = rounded_w >>> SHIFT;

    always_comb begin
        y_sat = shifted_w[DW-1:0];
        if (shifted_w > MAX_V) begin
            y_sat = MAX_V[DW-1:0];
        end else if (shifted_w < MIN_V) begin
            y_sat = MIN_V[DW-1:0];
        end
    end

endmodule

// File: rtl/fir_filter_mac.sv
// Time-multiplexed FIR filter: one shared MAC walks NTAPS taps per sample,
// runtime-loadable coefficients, valid/ready on both sides, rounded/saturated output.
module fir_filter_mac
    import fir_pkg::*;
#(
    parameter int DW    = 16,
    parameter int CW    = 16,
    parameter int NTAPS = 8,
    parameter int SHIFT = 15
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clr,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic signed [DW-1:0]           x_in,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic signed [DW-1:0]           y_out,
    input  logic                           coef_we,
    input  logic [fir_clog2(NTAPS)-1:0]    coef_addr,
    input  logic signed [CW-1:0]           coef_data,
    output logic                           coef_err
);

    localparam int AW = acc_width(DW, CW, NTAPS);
    localparam int KW = fir_clog2(NTAPS);
    localparam bit FULL_RANGE = ((1 << KW) == NTAPS);

    logic [1:0]             state_reg;
    logic [KW-1:0]          k_reg;
    logic signed [DW-1:0]   dly_reg  [NTAPS];
    logic signed [CW-1:0]   coef_reg [NTAPS];
    logic signed [AW-1:0]   acc_reg;
    logic signed [DW-1:0]   y_reg;
    logic                   out_valid_reg;
    logic                   coef_err_reg;

    logic signed [AW-1:0]   coef_ext;
    logic signed [AW-1:0]   dly_ext;
    logic signed [AW-1:0]   prod_w;
    logic signed [DW-1:0]   y_next;
    logic                   addr_ok;

    // Tap index doubles as the MAC counter: coef[k] pairs with the k-th newest sample.
    assign coef_ext = {{(AW-CW){coef_reg[k_reg][CW-1]}}, coef_reg[k_reg]};
    assign dly_ext  = {{(AW-DW){dly_reg[k_reg][DW-1]}}, dly_reg[k_reg]};
    assign prod_w   = coef_ext * dly_ext;

    generate
        if (FULL_RANGE) begin : g_addr_full
            assign addr_ok = 1'b1;
        end else begin : g_addr_part
            assign addr_ok = (int'(coef_addr) < NTAPS);
        end
    endgenerate

    fir_round_sat #(
        .AW    (AW),
        .DW    (DW),
        .SHIFT (SHIFT)
    ) u_round_sat (
        .acc_in (acc_reg),
        .y_sat  (y_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            k_reg         <= '0;
            acc_reg       <= '0;
            y_reg         <= '0;
            out_valid_reg <= 1'b0;
            coef_err_reg  <= 1'b0;
            for (int i = 0; i < NTAPS; i++) begin
                dly_reg[i]  <= '0;
                coef_reg[i] <= '0;
            end
        end else begin
            coef_err_reg <= 1'b0;
            if (clr) begin
                // Flush keeps the coefficient bank; any write in this cycle is ignored.
                state_reg     <= ST_IDLE;
                k_reg         <= '0;
                acc_reg       <= '0;
                out_valid_reg <= 1'b0;
                for (int i = 0; i < NTAPS; i++) begin
                    dly_reg[i] <= '0;
                end
            end else begin
                if (coef_we) begin
                    if (state_reg == ST_IDLE && addr_ok) begin
                        coef_reg[coef_addr] <= coef_data;
                    end else begin
                        coef_err_reg <= 1'b1;
                    end
                end
                case (state_reg)
                    ST_IDLE: begin
                        if (in_valid) begin
                            dly_reg[0] <= x_in;
                            for (int i = 1; i < NTAPS; i++) begin
                                dly_reg[i] <= dly_reg[i-1];
                            end
                            acc_reg   <= '0;
                            k_reg     <= '0;
                            state_reg <= ST_MAC;
                        end
                    end
                    ST_MAC: begin
                        acc_reg <= acc_reg + prod_w;
                        k_reg   <= k_reg + 1'b1;
                        if (k_reg == KW'(NTAPS - 1)) begin
                            state_reg <= ST_OUT;
                        end
                    end
                    ST_OUT: begin
                        // First OUT cycle registers the result; it then holds until taken.
                        if (!out_valid_reg) begin
                            y_reg         <= y_next;
                            out_valid_reg <= 1'b1;
                        end else if (out_ready) begin
                            out_valid_reg <= 1'b0;
                            state_reg     <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign in_ready  = (state_reg == ST_IDLE);
    assign out_valid = out_valid_reg;
    assign y_out     = y_reg;
    assign coef_err  = coef_err_reg;

endmodule

// File: tb/tb_fir_filter_mac.sv
// Self-checking bench: three filter instances (SHIFT 0, 1, 15) share stimulus and are
// compared against a plain-arithmetic FIR reference model.
module tb_fir_filter_mac;

    localparam int DW    = 16;
    localparam int CW    = 16;
    localparam int NTAPS = 4;
    localparam int TMO   = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic coef_we = 1'b0;
    logic signed [DW-1:0] x_in = '0;
    logic [1:0] coef_addr = '0;
    logic signed [CW-1:0] coef_data = '0;

    logic ir_s0, ir_s1, ir_s15;
    logic ov_s0, ov_s1, ov_s15;
    logic ce_s0, ce_s1, ce_s15;
    logic signed [DW-1:0] y_s0, y_s1, y_s15;

    int checks = 0;
    int errors = 0;
    int m_coef [NTAPS];
    int m_hist [NTAPS];

    always #5 clk = ~clk;

    fir_filter_mac #(.DW(DW), .CW(CW), .NTAPS(NTAPS), .SHIFT(0)) u_dut_s0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(ir_s0),
        .x_in(x_in), .out_valid(ov_s0), .out_ready(out_ready), .y_out(y_s0),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_err(ce_s0));

    fir_filter_mac #(.DW(DW), .CW(CW), .NTAPS(NTAPS), .SHIFT(1)) u_dut_s1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(ir_s1),
        .x_in(x_in), .out_valid(ov_s1), .out_ready(out_ready), .y_out(y_s1),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_err(ce_s1));

    fir_filter_mac #(.DW(DW), .CW(CW), .NTAPS(NTAPS), .SHIFT(15)) u_dut_s15 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(ir_s15),
        .x_in(x_in), .out_valid(ov_s15), .out_ready(out_ready), .y_out(y_s15),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_err(ce_s15));

    // Reference: y = sat(round(sum coef[k] * x[n-k])).
    function automatic logic signed [15:0] model_y(input int shift);
        longint acc;
        acc = 0;
        for (int k = 0; k < NTAPS; k++) begin
            acc += longint'(m_coef[k]) * longint'(m_hist[k]);
        end
        if (shift > 0) begin
            acc = (acc + (longint'(1) <<< (shift - 1))) >>> shift;
        end
        if (acc > 32767) acc = 32767;
        else if (acc < -32768) acc = -32768;
        return 16'(acc);
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < NTAPS; k++) begin
            m_coef[k] = 0;
            m_hist[k] = 0;
        end
    endfunction

    task automatic load_coefs(input int c0, input int c1, input int c2, input int c3);
        int cs [4];
        cs = '{c0, c1, c2, c3};
        for (int i = 0; i < NTAPS; i++) begin
            coef_we = 1'b1;
            coef_addr = 2'(i);
            coef_data = 16'(cs[i]);
            @(posedge clk); #1;
            m_coef[i] = int'(coef_data);
        end
        coef_we = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        for (int k = 0; k < NTAPS; k++) m_hist[k] = 0;
    endtask

    task automatic accept_sample(input int x, input bit we, input int addr, input int data);
        int n;
        n = 0;
        in_valid = 1'b1;
        x_in = 16'(x);
        coef_we = we;
        coef_addr = 2'(addr);
        coef_data = 16'(data);
        while (!ir_s0 && n < TMO) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ir_s0) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", ir_s0, n);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        coef_we = 1'b0;
        if (we) m_coef[addr] = int'(coef_data);
        for (int k = NTAPS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = int'(x_in);
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!ov_s0 && lat < TMO) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!ov_s0) begin
            checks++; errors++;
            $display("FAIL out_timeout: out_valid=%0b after %0d cycles, required 1", ov_s0, lat);
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        checks++;
        if ({ir_s0, ir_s1, ir_s15} !== 3'b111) begin
            errors++; $display("FAIL reset_in_ready: got %b required 111", {ir_s0, ir_s1, ir_s15});
        end
        checks++;
        if ({ov_s0, ov_s1, ov_s15} !== 3'b000) begin
            errors++; $display("FAIL reset_out_valid: got %b required 000", {ov_s0, ov_s1, ov_s15});
        end
        checks++;
        if ({y_s0, y_s1, y_s15} !== 48'd0) begin
            errors++; $display("FAIL reset_y_out: got %0d/%0d/%0d required 0", y_s0, y_s1, y_s15);
        end
        checks++;
        if ({ce_s0, ce_s1, ce_s15} !== 3'b000) begin
            errors++; $display("FAIL reset_coef_err: got %b required 000", {ce_s0, ce_s1, ce_s15});
        end
    endtask

    task automatic test_ramp();
        int xs [5];
        int ys [5];
        int lat;
        xs = '{1, 2, 3, 4, 5};
        ys = '{1, 4, 10, 20, 30};
        load_coefs(1, 2, 3, 4);
        for (int i = 0; i < 5; i++) begin
            accept_sample(xs[i], 1'b0, 0, 0);
            wait_out(lat);
            checks++;
            if (lat != NTAPS + 1) begin
                errors++; $display("FAIL ramp_latency[%0d]: got %0d required %0d", i, lat, NTAPS + 1);
            end
            checks++;
            if (y_s0 !== 16'(ys[i])) begin
                errors++; $display("FAIL ramp_y[%0d]: got %0d required %0d", i, y_s0, ys[i]);
            end
            checks++;
            if (y_s15 !== model_y(15)) begin
                errors++; $display("FAIL ramp_y_s15[%0d]: got %0d required %0d", i, y_s15, model_y(15));
            end
            release_out();
        end
    endtask

    task automatic test_saturation();
        int lat;
        load_coefs(32767, 32767, 32767, 32767);
        for (int i = 0; i < 8; i++) begin
            accept_sample((i < 4) ? 32767 : -32768, 1'b0, 0, 0);
            wait_out(lat);
            checks++;
            if (y_s0 !== model_y(0) || y_s15 !== model_y(15)) begin
                errors++;
                $display("FAIL sat_y[%0d]: got %0d/%0d required %0d/%0d", i, y_s0, y_s15, model_y(0), model_y(15));
            end
            if (i == 3) begin
                checks++;
                if (y_s0 !== 16'sh7FFF) begin
                    errors++; $display("FAIL sat_pos: got %h required 7fff", y_s0);
                end
            end
            if (i == 7) begin
                checks++;
                if (y_s0 !== 16'sh8000) begin
                    errors++; $display("FAIL sat_neg: got %h required 8000", y_s0);
                end
            end
            release_out();
        end
    endtask

    task automatic test_rounding();
        int lat;
        load_coefs(1, 0, 0, 0);
        accept_sample(3, 1'b0, 0, 0);
        wait_out(lat);
        checks++;
        if (y_s1 !== 16'sd2 || y_s0 !== 16'sd3) begin
            errors++; $display("FAIL round_pos: got %0d/%0d required 2/3", y_s1, y_s0);
        end
        // Flush while the result is still pending: it must be dropped.
        pulse_clr();
        checks++;
        if (ov_s0 !== 1'b0 || ir_s0 !== 1'b1) begin
            errors++; $display("FAIL clr_drop: out_valid=%0b in_ready=%0b required 0/1", ov_s0, ir_s0);
        end
        accept_sample(-3, 1'b0, 0, 0);
        wait_out(lat);
        checks++;
        if (y_s1 !== -16'sd1 || y_s15 !== model_y(15)) begin
            errors++; $display("FAIL round_neg: got %0d/%0d required -1/%0d", y_s1, y_s15, model_y(15));
        end
        release_out();
    endtask

    task automatic test_backpressure();
        int lat;
        logic signed [15:0] held;
        accept_sample(100, 1'b0, 0, 0);
        wait_out(lat);
        held = model_y(0);
        in_valid = 1'b1;
        x_in = 16'sd555;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if (ov_s0 !== 1'b1 || y_s0 !== held || ir_s0 !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: valid=%0b y=%0d ready=%0b required 1/%0d/0", c, ov_s0, y_s0, ir_s0, held);
            end
        end
        in_valid = 1'b0;
        release_out();
        load_coefs(1, 1, 0, 0);
        accept_sample(7, 1'b0, 0, 0);
        wait_out(lat);
        checks++;
        if (y_s0 !== 16'sd107) begin
            errors++; $display("FAIL bp_not_consumed: got %0d required 107", y_s0);
        end
        release_out();
    endtask

    task automatic test_coef_write();
        int lat;
        load_coefs(1, 2, 3, 4);
        accept_sample(10, 1'b0, 0, 0);
        @(posedge clk); #1;
        coef_we = 1'b1; coef_addr = 2'd0; coef_data = 16'sd100;
        @(posedge clk); #1;
        coef_we = 1'b0;
        checks++;
        if (ce_s0 !== 1'b1) begin
            errors++; $display("FAIL coef_err_mac: got %0b required 1", ce_s0);
        end
        @(posedge clk); #1;
        checks++;
        if (ce_s0 !== 1'b0) begin
            errors++; $display("FAIL coef_err_pulse: got %0b required 0", ce_s0);
        end
        wait_out(lat);
        checks++;
        if (y_s0 !== model_y(0)) begin
            errors++; $display("FAIL coef_mac_dropped: got %0d required %0d", y_s0, model_y(0));
        end
        coef_we = 1'b1; coef_addr = 2'd1; coef_data = 16'sd50;
        @(posedge clk); #1;
        coef_we = 1'b0;
        checks++;
        if (ce_s0 !== 1'b1) begin
            errors++; $display("FAIL coef_err_out: got %0b required 1", ce_s0);
        end
        release_out();
        accept_sample(2, 1'b1, 0, -7);
        checks++;
        if (ce_s0 !== 1'b0) begin
            errors++; $display("FAIL coef_err_idle: got %0b required 0", ce_s0);
        end
        wait_out(lat);
        checks++;
        if (y_s0 !== model_y(0)) begin
            errors++; $display("FAIL coef_same_cycle: got %0d required %0d", y_s0, model_y(0));
        end
        release_out();
    endtask

    task automatic test_reset_mid();
        int lat;
        load_coefs(1, 2, 3, 4);
        accept_sample(9, 1'b0, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ov_s0 !== 1'b0 || y_s0 !== 16'sd0 || ir_s0 !== 1'b1) begin
            errors++; $display("FAIL rst_mid: valid=%0b y=%0d ready=%0b required 0/0/1", ov_s0, y_s0, ir_s0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        repeat (NTAPS + 3) @(posedge clk);
        #1;
        checks++;
        if (ov_s0 !== 1'b0) begin
            errors++; $display("FAIL rst_no_partial: out_valid=%0b required 0", ov_s0);
        end
        load_coefs(1, 2, 3, 4);
        accept_sample(1, 1'b0, 0, 0);
        wait_out(lat);
        checks++;
        if (y_s0 !== 16'sd1) begin
            errors++; $display("FAIL rst_after_y: got %0d required 1", y_s0);
        end
        release_out();
    endtask

    task automatic test_random();
        int lat;
        int x;
        int hold;
        bit we;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                coef_we = 1'b1;
                coef_addr = 2'($urandom_range(0, 3));
                coef_data = 16'($urandom_range(0, 65535));
                @(posedge clk); #1;
                coef_we = 1'b0;
                m_coef[coef_addr] = int'(coef_data);
            end
            we = ($urandom_range(0, 2) == 0);
            x = int'($urandom_range(0, 65535)) - 32768;
            accept_sample(x, we, int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)) - 32768);
            if ($urandom_range(0, 2) == 0) begin
                coef_we = 1'b1;
                coef_addr = 2'($urandom_range(0, 3));
                coef_data = 16'($urandom_range(0, 65535));
                @(posedge clk); #1;
                coef_we = 1'b0;
                checks++;
                if (ce_s0 !== 1'b1) begin
                    errors++; $display("FAIL rand_coef_err[%0d]: got %0b required 1", i, ce_s0);
                end
            end
            wait_out(lat);
            checks++;
            if (y_s0 !== model_y(0) || y_s1 !== model_y(1) || y_s15 !== model_y(15)) begin
                errors++;
                $display("FAIL rand_y[%0d]: got %0d/%0d/%0d required %0d/%0d/%0d", i,
                         y_s0, y_s1, y_s15, model_y(0), model_y(1), model_y(15));
            end
            hold = int'($urandom_range(0, 3));
            repeat (hold) @(posedge clk);
            #1;
            release_out();
            if ($urandom_range(0, 7) == 0) pulse_clr();
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_saturation();
        test_rounding();
        test_backpressure();
        test_coef_write();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
